// File: rtl/adder_pkg.sv
// ============================================================================
//  Module   : adder_pkg
//  Purpose  : Shared register offsets, CTRL bit positions and engine state type
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam logic [1:0] ADDR_OPA    = 2'd0;
  localparam logic [1:0] ADDR_OPB    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_CARRY = 2;
  localparam int CTRL_IE    = 3;
  localparam int CTRL_BUSY  = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    ENG_IDLE = 1'b0,
    ENG_BUSY = 1'b1
  } eng_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_core.sv
// ============================================================================
//  Module   : adder_core
//  Purpose  : Multi-cycle 32+32 -> 33 bit adder with latched operands
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_core
  import adder_pkg::*;
#(
  parameter int ADD_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic [32:0] sum_o,
  output logic        done_o,
  output logic        busy_o
);

  localparam logic [3:0] LAT_M1 = 4'(ADD_LATENCY - 1);

  eng_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ENG_IDLE;
      cnt_q   <= 4'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  // A start request while busy is dropped; operands stay as latched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    done_o  = 1'b0;
    case (state_q)
      ENG_IDLE: begin
        if (start_i) begin
          state_d = ENG_BUSY;
          cnt_d   = LAT_M1;
          opa_d   = opa_i;
          opb_d   = opb_i;
        end
      end
      ENG_BUSY: begin
        if (cnt_q == 4'd0) begin
          done_o  = 1'b1;
          state_d = ENG_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  assign busy_o = (state_q == ENG_BUSY);
  assign sum_o  = {1'b0, opa_q} + {1'b0, opb_q};

endmodule

`default_nettype wire

// File: rtl/adder_axil_slave.sv
// ============================================================================
//  Module   : adder_axil_slave
//  Purpose  : AXI4-Lite register front end (OPA/OPB/CTRL/RESULT) for adder_core
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_axil_slave
  import adder_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ADD_LATENCY        = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  logic        aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [1:0]  awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] opa_q, opb_q, result_q, rdata_q;
  logic        done_q, carry_q, ie_q;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_ctrl_wr, w_start;
  logic [32:0] w_core_sum;
  logic        w_core_done, w_core_busy;
  logic [31:0] w_ctrl_rd, w_rd_mux;
  logic        w_unused;

  // Readies are held low while reset is asserted.
  assign S_AXI_AWREADY = ARESETN && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = ARESETN && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = ARESETN && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign irq           = done_q && ie_q;

  assign w_aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_commit  = aw_held_q && w_held_q;
  assign w_ctrl_wr = w_commit && (awaddr_q == ADDR_CTRL) && wstrb_q[0];
  assign w_start   = w_ctrl_wr && wdata_q[CTRL_START];

  assign w_ctrl_rd = {27'd0, w_core_busy, ie_q, carry_q, done_q, 1'b0};

  always_comb begin
    w_rd_mux = 32'd0;
    case (S_AXI_ARADDR[3:2])
      ADDR_OPA:    w_rd_mux = opa_q;
      ADDR_OPB:    w_rd_mux = opb_q;
      ADDR_CTRL:   w_rd_mux = w_ctrl_rd;
      ADDR_RESULT: w_rd_mux = result_q;
      default:     w_rd_mux = 32'd0;
    endcase
  end

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  adder_core #(
    .ADD_LATENCY (ADD_LATENCY)
  ) u_core (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .start_i (w_start),
    .opa_i   (opa_q),
    .opb_i   (opb_q),
    .sum_o   (w_core_sum),
    .done_o  (w_core_done),
    .busy_o  (w_core_busy)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      awaddr_q  <= 2'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      result_q  <= 32'd0;
      rdata_q   <= 32'd0;
      done_q    <= 1'b0;
      carry_q   <= 1'b0;
      ie_q      <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= S_AXI_AWADDR[3:2];
      end
      if (w_w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      if (w_commit) begin
        case (awaddr_q)
          ADDR_OPA: opa_q <= apply_wstrb(opa_q, wdata_q, wstrb_q);
          ADDR_OPB: opb_q <= apply_wstrb(opb_q, wdata_q, wstrb_q);
          default:  ;
        endcase
      end

      // Later assignments take priority: START over W1C, engine set over W1C.
      if (w_ctrl_wr) begin
        ie_q <= wdata_q[CTRL_IE];
        if (wdata_q[CTRL_DONE]) done_q <= 1'b0;
        if (wdata_q[CTRL_START] && !w_core_busy) begin
          done_q  <= 1'b0;
          carry_q <= 1'b0;
        end
      end
      if (w_core_done) begin
        done_q   <= 1'b1;
        carry_q  <= w_core_sum[32];
        result_q <= w_core_sum[31:0];
      end

      if (w_ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= w_rd_mux;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_axil_slave.sv
// ============================================================================
//  Module   : tb_adder_axil_slave
//  Purpose  : Directed self-checking bench for adder_axil_slave
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_axil_slave;

  localparam int LAT = 12;
  localparam int TMO = 60;

  logic        ACLK, ARESETN;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        irq;

  int checks = 0;
  int errors = 0;

  adder_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .ADD_LATENCY        (LAT)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .irq           (irq)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic hs_aw(input logic [3:0] a);
    int n = 0;
    S_AXI_AWADDR  = a;
    S_AXI_AWVALID = 1'b1;
    while (!S_AXI_AWREADY && n < TMO) begin tick(1); n++; end
    chk("aw_timeout", n < TMO, 1);
    tick(1);
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    S_AXI_WVALID = 1'b1;
    while (!S_AXI_WREADY && n < TMO) begin tick(1); n++; end
    chk("w_timeout", n < TMO, 1);
    tick(1);
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int  n = 0;
    logic awf, wf;
    S_AXI_AWADDR  = a;  S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = d;  S_AXI_WSTRB   = s;  S_AXI_WVALID = 1'b1;
    S_AXI_BREADY  = 1'b1;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && n < TMO) begin
      awf = S_AXI_AWVALID && S_AXI_AWREADY;
      wf  = S_AXI_WVALID && S_AXI_WREADY;
      tick(1);
      if (awf) S_AXI_AWVALID = 1'b0;
      if (wf)  S_AXI_WVALID  = 1'b0;
      n++;
    end
    n = 0;
    while (!S_AXI_BVALID && n < TMO) begin tick(1); n++; end
    chk("b_timeout", n < TMO, 1);
    tick(1);
    S_AXI_BREADY  = 1'b0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < TMO) begin tick(1); n++; end
    tick(1);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < TMO) begin tick(1); n++; end
    chk("r_timeout", n < TMO, 1);
    d = S_AXI_RDATA;
    r = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick(1);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk(tag, d, exp);
  endtask

  task automatic wait_irq(input string tag, output int n);
    n = 0;
    while (!irq && n < TMO) begin tick(1); n++; end
    chk(tag, n < TMO, 1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  int          cyc;

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA  = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    // Reset and post-reset register contents
    tick(10);
    ARESETN = 1'b1;
    tick(1);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_irq", irq, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, rr);
      chk("rst_rdata", rd, 0);
      chk("rst_rresp", rr, 0);
    end

    // 5 + 7 with IE, checking DONE latency
    axi_write(4'h0, 32'h0000_0005, 4'hF);
    axi_write(4'h4, 32'h0000_0007, 4'hF);
    axi_write(4'h8, 32'h0000_0009, 4'hF);
    wait_irq("add1_irq_tmo", cyc);
    chk("add1_latency", cyc, LAT - 1);
    rd_chk("add1_result", 4'hC, 32'h0000_000C);
    rd_chk("add1_ctrl", 4'h8, 32'h0000_000A);
    chk("add1_irq", irq, 1);

    // Carry out of bit 31
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'h4, 32'h0000_0002, 4'hF);
    axi_write(4'h8, 32'h0000_0009, 4'hF);
    chk("add2_irq_cleared", irq, 0);
    wait_irq("add2_irq_tmo", cyc);
    rd_chk("add2_result", 4'hC, 32'h0000_0001);
    rd_chk("add2_ctrl", 4'h8, 32'h0000_000E);

    // Byte strobes, RESULT read-only, DONE W1C (CARRY kept)
    axi_write(4'h0, 32'hAABB_CCDD, 4'b0101);
    rd_chk("strb_opa", 4'h0, 32'hFFBB_FFDD);
    axi_write(4'hC, 32'h0000_1234, 4'hF);
    rd_chk("result_ro", 4'hC, 32'h0000_0001);
    axi_write(4'h8, 32'h0000_000A, 4'hF);
    rd_chk("w1c_ctrl", 4'h8, 32'h0000_000C);
    chk("w1c_irq", irq, 0);

    // AW three cycles ahead of W, BREADY held low
    S_AXI_BREADY = 1'b0;
    hs_aw(4'h4);
    chk("split_awready_held", S_AXI_AWREADY, 0);
    tick(2);
    hs_w(32'h0000_0055, 4'hF);
    chk("split_bvalid_early", S_AXI_BVALID, 0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("split_bvalid_hold", S_AXI_BVALID, 1);
      chk("split_awready_blk", S_AXI_AWREADY, 0);
      chk("split_bresp", S_AXI_BRESP, 0);
      tick(1);
    end
    S_AXI_BREADY = 1'b1;
    tick(1);
    S_AXI_BREADY = 1'b0;
    chk("split_bvalid_drop", S_AXI_BVALID, 0);
    chk("split_awready_back", S_AXI_AWREADY, 1);
    rd_chk("split_opb", 4'h4, 32'h0000_0055);

    // Second START and OPA write while BUSY
    axi_write(4'h0, 32'h0000_0003, 4'hF);
    axi_write(4'h4, 32'h0000_0004, 4'hF);
    axi_write(4'h8, 32'h0000_0009, 4'hF);
    rd_chk("busy_ctrl", 4'h8, 32'h0000_0018);
    axi_write(4'h0, 32'h0000_0100, 4'hF);
    axi_write(4'h8, 32'h0000_0009, 4'hF);
    tick(30);
    rd_chk("busy_result", 4'hC, 32'h0000_0007);
    rd_chk("busy_opa", 4'h0, 32'h0000_0100);
    rd_chk("busy_ctrl_done", 4'h8, 32'h0000_000A);
    axi_write(4'h8, 32'h0000_000A, 4'hF);
    tick(30);
    rd_chk("busy_single_done", 4'h8, 32'h0000_0008);

    // Reset with a pending B response and the engine busy
    S_AXI_BREADY = 1'b0;
    hs_aw(4'h8);
    hs_w(32'h0000_0009, 4'hF);
    tick(1);
    chk("mid_bvalid_pend", S_AXI_BVALID, 1);
    rd_chk("mid_ctrl_busy", 4'h8, 32'h0000_0018);
    ARESETN = 1'b0;
    tick(3);
    ARESETN = 1'b1;
    S_AXI_BREADY = 1'b1;
    tick(3);
    chk("mid_bvalid", S_AXI_BVALID, 0);
    chk("mid_rvalid", S_AXI_RVALID, 0);
    chk("mid_irq", irq, 0);
    S_AXI_BREADY = 1'b0;
    rd_chk("mid_ctrl", 4'h8, 32'h0000_0000);
    rd_chk("mid_opa", 4'h0, 32'h0000_0000);
    rd_chk("mid_opb", 4'h4, 32'h0000_0000);
    rd_chk("mid_result", 4'hC, 32'h0000_0000);
    tick(LAT + 4);
    chk("mid_no_done", irq, 0);
    rd_chk("mid_ctrl_late", 4'h8, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
